// File: rtl/channel_ctrl.sv
// channel_ctrl: per-channel controller for one analog front-end channel.
// Waits for a discriminator hit or forced trigger, holds the CSA, strobes the
// SAR ADC, captures the result with a timestamp into a one-entry valid/ready
// buffer, then resets the CSA and re-arms.

// Two-flop synchronizer for a single asynchronous level.
module channel_ctrl_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two register stages; only sync_q is safe to use in the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

module channel_ctrl #(
  parameter int unsigned ADCBITS      = 10,
  parameter int unsigned TS_BITS      = 24,
  parameter int unsigned CONV_TIMEOUT = 63
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         channel_enable,
  input  logic                         external_trigger,
  input  logic                         hit,
  input  logic                         done,
  input  logic [ADCBITS-1:0]           dout,
  input  logic [TS_BITS-1:0]           timestamp,
  input  logic [3:0]                   adc_hold_delay,
  input  logic [7:0]                   csa_reset_cycles,
  output logic                         sample,
  output logic                         strobe,
  output logic                         csa_reset,
  output logic                         event_valid,
  input  logic                         event_ready,
  output logic [ADCBITS+TS_BITS+2:0]   event_data,
  output logic                         overflow
);

  localparam int unsigned EVW = ADCBITS + TS_BITS + 3;
  // Timeout counter runs 0 .. CONV_TIMEOUT-1.
  localparam int unsigned TOW = (CONV_TIMEOUT < 2) ? 1 : $clog2(CONV_TIMEOUT);
  localparam logic [TOW-1:0] TMR_LAST = TOW'(CONV_TIMEOUT - 1);

  localparam logic [2:0] ST_DISABLED  = 3'd0;
  localparam logic [2:0] ST_READY     = 3'd1;
  localparam logic [2:0] ST_HOLD      = 3'd2;
  localparam logic [2:0] ST_STROBE    = 3'd3;
  localparam logic [2:0] ST_WAIT_DONE = 3'd4;
  localparam logic [2:0] ST_STORE     = 3'd5;
  localparam logic [2:0] ST_CSA_RST   = 3'd6;

  logic               hit_sync;
  logic               done_sync;
  logic               hit_prev_q;
  logic               hit_edge;
  logic               trigger;
  logic               load_ok;

  logic [2:0]         state_q,    state_d;
  logic [7:0]         cnt_q,      cnt_d;
  logic [TOW-1:0]     tmr_q,      tmr_d;
  logic [TS_BITS-1:0] ts_q,       ts_d;
  logic [1:0]         trig_q,     trig_d;
  logic [ADCBITS-1:0] adc_q,      adc_d;
  logic               err_q,      err_d;
  logic [EVW-1:0]     ev_data_q,  ev_data_d;
  logic               ev_valid_q, ev_valid_d;
  logic               ovf_q,      ovf_d;
  logic               sample_q,   sample_d;
  logic               strobe_q,   strobe_d;
  logic               csa_q,      csa_d;

  channel_ctrl_sync u_hit_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d_i   (hit),
    .q_o   (hit_sync)
  );

  channel_ctrl_sync u_done_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d_i   (done),
    .q_o   (done_sync)
  );

  assign hit_edge = hit_sync & ~hit_prev_q;
  assign trigger  = hit_edge | external_trigger;
  // The buffer can take a new event if empty or being drained this cycle.
  assign load_ok  = ~ev_valid_q | event_ready;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tmr_d      = tmr_q;
    ts_d       = ts_q;
    trig_d     = trig_q;
    adc_d      = adc_q;
    err_d      = err_q;
    ev_data_d  = ev_data_q;
    ev_valid_d = ev_valid_q;
    ovf_d      = 1'b0;

    if (ev_valid_q && event_ready) begin
      ev_valid_d = 1'b0;
    end

    case (state_q)
      ST_DISABLED: begin
        if (channel_enable) begin
          state_d = ST_READY;
        end
      end

      ST_READY: begin
        if (trigger) begin
          ts_d   = timestamp;
          trig_d = {external_trigger, hit_edge};
          // A zero hold delay releases sample on the trigger edge itself,
          // so HOLD is skipped rather than spending one cycle at count 0.
          if (adc_hold_delay == 4'd0) begin
            state_d = ST_STROBE;
          end else begin
            cnt_d   = {4'b0000, adc_hold_delay};
            state_d = ST_HOLD;
          end
        end else if (!channel_enable) begin
          state_d = ST_DISABLED;
        end
      end

      ST_HOLD: begin
        if (cnt_q <= 8'd1) begin
          state_d = ST_STROBE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      ST_STROBE: begin
        tmr_d   = '0;
        state_d = ST_WAIT_DONE;
      end

      ST_WAIT_DONE: begin
        if (done_sync) begin
          adc_d   = dout;
          err_d   = 1'b0;
          state_d = ST_STORE;
        end else if (tmr_q == TMR_LAST) begin
          adc_d   = dout;
          err_d   = 1'b1;
          state_d = ST_STORE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      ST_STORE: begin
        if (load_ok) begin
          ev_data_d  = {err_q, trig_q, ts_q, adc_q};
          ev_valid_d = 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
        cnt_d   = (csa_reset_cycles == 8'd0) ? 8'd1 : csa_reset_cycles;
        state_d = ST_CSA_RST;
      end

      ST_CSA_RST: begin
        if (cnt_q <= 8'd1) begin
          state_d = channel_enable ? ST_READY : ST_DISABLED;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      default: begin
        state_d = ST_DISABLED;
      end
    endcase

    // Outputs are decoded from the next state so they change on the same
    // edge as the state register and are glitch-free.
    sample_d = !((state_d == ST_STROBE) || (state_d == ST_WAIT_DONE) ||
                 (state_d == ST_STORE));
    strobe_d = (state_d == ST_STROBE);
    csa_d    = (state_d == ST_DISABLED) || (state_d == ST_CSA_RST);
  end

  // State, datapath and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_DISABLED;
      hit_prev_q <= 1'b0;
      cnt_q      <= '0;
      tmr_q      <= '0;
      ts_q       <= '0;
      trig_q     <= '0;
      adc_q      <= '0;
      err_q      <= 1'b0;
      ev_data_q  <= '0;
      ev_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      sample_q   <= 1'b1;
      strobe_q   <= 1'b0;
      csa_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      hit_prev_q <= hit_sync;
      cnt_q      <= cnt_d;
      tmr_q      <= tmr_d;
      ts_q       <= ts_d;
      trig_q     <= trig_d;
      adc_q      <= adc_d;
      err_q      <= err_d;
      ev_data_q  <= ev_data_d;
      ev_valid_q <= ev_valid_d;
      ovf_q      <= ovf_d;
      sample_q   <= sample_d;
      strobe_q   <= strobe_d;
      csa_q      <= csa_d;
    end
  end

  assign sample      = sample_q;
  assign strobe      = strobe_q;
  assign csa_reset   = csa_q;
  assign event_valid = ev_valid_q;
  assign event_data  = ev_data_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_channel_ctrl.sv
// tb_channel_ctrl: directed bench for channel_ctrl with an event scoreboard.
module tb_channel_ctrl;

  localparam int unsigned ADCBITS      = 10;
  localparam int unsigned TS_BITS      = 24;
  localparam int unsigned CONV_TIMEOUT = 63;
  localparam int unsigned EVW          = ADCBITS + TS_BITS + 3;

  logic               clk;
  logic               reset_n;
  logic               channel_enable;
  logic               external_trigger;
  logic               hit;
  logic               done;
  logic [ADCBITS-1:0] dout;
  logic [TS_BITS-1:0] timestamp;
  logic [3:0]         adc_hold_delay;
  logic [7:0]         csa_reset_cycles;
  logic               sample;
  logic               strobe;
  logic               csa_reset;
  logic               event_valid;
  logic               event_ready;
  logic [EVW-1:0]     event_data;
  logic               overflow;

  int             vectors;
  int             miscompares;
  logic [EVW-1:0] exp_q[$];

  channel_ctrl #(
    .ADCBITS      (ADCBITS),
    .TS_BITS      (TS_BITS),
    .CONV_TIMEOUT (CONV_TIMEOUT)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .channel_enable   (channel_enable),
    .external_trigger (external_trigger),
    .hit              (hit),
    .done             (done),
    .dout             (dout),
    .timestamp        (timestamp),
    .adc_hold_delay   (adc_hold_delay),
    .csa_reset_cycles (csa_reset_cycles),
    .sample           (sample),
    .strobe           (strobe),
    .csa_reset        (csa_reset),
    .event_valid      (event_valid),
    .event_ready      (event_ready),
    .event_data       (event_data),
    .overflow         (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [EVW-1:0] mk(input logic err, input logic [1:0] trig,
                                        input logic [TS_BITS-1:0] ts,
                                        input logic [ADCBITS-1:0] adc);
    return {err, trig, ts, adc};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fire_ext();
    external_trigger = 1'b1;
    tick();
    external_trigger = 1'b0;
  endtask

  task automatic wait_strobe(output int n);
    n = 0;
    while (!strobe && n < 200) begin
      tick();
      n++;
    end
  endtask

  // Called in the STROBE cycle; returns in the STORE cycle.
  task automatic to_store(input logic [ADCBITS-1:0] d);
    dout = d;
    done = 1'b1;
    tick();
    chk("strobe_one_cycle", 64'(strobe), 64'd0);
    tick();
    tick();
  endtask

  task automatic wait_csa_low();
    int n;
    n = 0;
    while (csa_reset && n < 300) begin
      tick();
      n++;
    end
  endtask

  task automatic consume();
    int n;
    logic [EVW-1:0] e;
    n = 0;
    while (!event_valid && n < 200) begin
      tick();
      n++;
    end
    chk("consume_valid", 64'(event_valid), 64'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    chk("event_data", 64'(event_data), 64'(e));
    event_ready = 1'b1;
    tick();
    event_ready = 1'b0;
    chk("valid_clears", 64'(event_valid), 64'd0);
  endtask

  initial begin
    int n;
    int s;
    logic [EVW-1:0] ev_c;
    vectors          = 0;
    miscompares      = 0;
    reset_n          = 1'b0;
    channel_enable   = 1'b0;
    external_trigger = 1'b0;
    hit              = 1'b0;
    done             = 1'b0;
    dout             = '0;
    timestamp        = '0;
    adc_hold_delay   = 4'd3;
    csa_reset_cycles = 8'd4;
    event_ready      = 1'b0;

    // Reset values
    repeat (2) tick();
    chk("rst_sample", 64'(sample), 64'd1);
    chk("rst_strobe", 64'(strobe), 64'd0);
    chk("rst_csa", 64'(csa_reset), 64'd1);
    chk("rst_valid", 64'(event_valid), 64'd0);
    chk("rst_data", 64'(event_data), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    reset_n = 1'b1;
    repeat (2) tick();
    chk("disabled_csa", 64'(csa_reset), 64'd1);

    channel_enable = 1'b1;
    tick();
    chk("ready_csa", 64'(csa_reset), 64'd0);

    // Basic hit: two sync stages plus the edge detect, then 3 hold cycles
    timestamp = 24'h000100;
    hit = 1'b1;
    wait_strobe(n);
    chk("basic_strobe_latency", 64'(n), 64'd6);
    chk("basic_sample_low", 64'(sample), 64'd0);
    to_store(10'h2A5);
    tick();
    done = 1'b0;
    exp_q.push_back(mk(1'b0, 2'b01, 24'h000100, 10'h2A5));
    chk("basic_valid", 64'(event_valid), 64'd1);
    chk("basic_ovf", 64'(overflow), 64'd0);
    n = 0;
    while (csa_reset && n < 50) begin
      tick();
      n++;
    end
    chk("basic_csa_len", 64'(n), 64'd4);
    chk("basic_rearm_sample", 64'(sample), 64'd1);
    // Hit still held: no retrigger
    s = 0;
    repeat (90) begin
      tick();
      if (strobe) s++;
    end
    chk("held_hit_no_retrigger", 64'(s), 64'd0);
    hit = 1'b0;
    consume();
    repeat (4) tick();

    // Hit edge and external trigger in the same cycle; csa_reset_cycles=0
    adc_hold_delay   = 4'd2;
    csa_reset_cycles = 8'd0;
    timestamp = 24'h123456;
    hit = 1'b1;
    tick();
    tick();
    fire_ext();
    timestamp = 24'h000000;
    wait_strobe(n);
    chk("both_strobe_latency", 64'(n), 64'd2);
    to_store(10'h155);
    tick();
    done = 1'b0;
    exp_q.push_back(mk(1'b0, 2'b11, 24'h123456, 10'h155));
    n = 0;
    while (csa_reset && n < 50) begin
      tick();
      n++;
    end
    chk("csa_len_zero_is_one", 64'(n), 64'd1);
    hit = 1'b0;
    consume();
    repeat (4) tick();

    // Timeout with zero hold delay
    adc_hold_delay   = 4'd0;
    csa_reset_cycles = 8'd2;
    timestamp = 24'hABCDEF;
    dout = 10'h3FF;
    fire_ext();
    timestamp = 24'h000000;
    chk("hold0_strobe", 64'(strobe), 64'd1);
    chk("hold0_sample", 64'(sample), 64'd0);
    n = 0;
    while (!csa_reset && n < 200) begin
      tick();
      n++;
    end
    chk("timeout_latency", 64'(n), 64'(CONV_TIMEOUT + 2));
    exp_q.push_back(mk(1'b1, 2'b10, 24'hABCDEF, 10'h3FF));
    consume();
    wait_csa_low();
    chk("timeout_rearm", 64'(csa_reset), 64'd0);

    // Overflow: buffer full, second event dropped
    adc_hold_delay = 4'd1;
    timestamp = 24'h000200;
    fire_ext();
    wait_strobe(n);
    to_store(10'h011);
    tick();
    done = 1'b0;
    exp_q.push_back(mk(1'b0, 2'b10, 24'h000200, 10'h011));
    chk("ovfA_pulse", 64'(overflow), 64'd0);
    chk("ovfA_valid", 64'(event_valid), 64'd1);
    wait_csa_low();
    timestamp = 24'h000201;
    fire_ext();
    wait_strobe(n);
    to_store(10'h022);
    tick();
    done = 1'b0;
    chk("ovfB_pulse", 64'(overflow), 64'd1);
    chk("ovfB_data_kept", 64'(event_data), 64'(exp_q[0]));
    tick();
    chk("ovfB_pulse_single", 64'(overflow), 64'd0);
    wait_csa_low();
    // Third event: ready rises during STORE, so reload instead of overflow
    timestamp = 24'h000202;
    fire_ext();
    wait_strobe(n);
    to_store(10'h022);
    event_ready = 1'b1;
    chk("ovfC_valid_before", 64'(event_valid), 64'd1);
    chk("ovfC_old_data", 64'(event_data), 64'(exp_q.pop_front()));
    tick();
    event_ready = 1'b0;
    done = 1'b0;
    ev_c = mk(1'b0, 2'b10, 24'h000202, 10'h022);
    exp_q.push_back(ev_c);
    chk("ovfC_no_ovf", 64'(overflow), 64'd0);
    chk("ovfC_valid", 64'(event_valid), 64'd1);
    chk("ovfC_new_data", 64'(event_data), 64'(ev_c));
    consume();
    wait_csa_low();

    // Disable mid-conversion
    csa_reset_cycles = 8'd3;
    timestamp = 24'h000400;
    fire_ext();
    wait_strobe(n);
    channel_enable = 1'b0;
    to_store(10'h1C3);
    tick();
    done = 1'b0;
    exp_q.push_back(mk(1'b0, 2'b10, 24'h000400, 10'h1C3));
    chk("dis_valid", 64'(event_valid), 64'd1);
    repeat (10) tick();
    chk("dis_csa_held", 64'(csa_reset), 64'd1);
    s = 0;
    external_trigger = 1'b1;
    tick();
    external_trigger = 1'b0;
    hit = 1'b1;
    repeat (8) begin
      tick();
      if (strobe || !sample) s++;
    end
    hit = 1'b0;
    repeat (4) tick();
    chk("dis_ignore_triggers", 64'(s), 64'd0);
    consume();
    channel_enable = 1'b1;
    tick();
    chk("reenable_csa", 64'(csa_reset), 64'd0);

    // Async reset during HOLD with a buffered event
    adc_hold_delay   = 4'd0;
    csa_reset_cycles = 8'd1;
    timestamp = 24'h000500;
    fire_ext();
    to_store(10'h0AA);
    tick();
    done = 1'b0;
    wait_csa_low();
    adc_hold_delay = 4'd8;
    fire_ext();
    tick();
    chk("pre_reset_valid", 64'(event_valid), 64'd1);
    chk("pre_reset_csa", 64'(csa_reset), 64'd0);
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_sample", 64'(sample), 64'd1);
    chk("arst_csa", 64'(csa_reset), 64'd1);
    chk("arst_strobe", 64'(strobe), 64'd0);
    chk("arst_valid", 64'(event_valid), 64'd0);
    chk("arst_data", 64'(event_data), 64'd0);
    exp_q.delete();
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    chk("post_reset_valid", 64'(event_valid), 64'd0);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
